// File: rtl/axi_lite_mem_arbiter.sv
// axi_lite_mem_arbiter
// Shares one AXI-lite RAM slave port between the IFU (read only) and the
// LSU (read + write). One transaction is in flight at a time; the grant is
// held from the address handshake through the response handshake.
module axi_lite_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int PRIO_LSU = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    // IFU read channels
    input  logic                  ifu_arvalid,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    output logic                  ifu_arready,
    output logic                  ifu_rvalid,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    input  logic                  ifu_rready,
    // LSU read channels
    input  logic                  lsu_arvalid,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    output logic                  lsu_arready,
    output logic                  lsu_rvalid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    input  logic                  lsu_rready,
    // LSU write channels
    input  logic                  lsu_awvalid,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    output logic                  lsu_awready,
    input  logic                  lsu_wvalid,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_wready,
    output logic                  lsu_bvalid,
    output logic [1:0]            lsu_bresp,
    input  logic                  lsu_bready,
    // RAM slave side
    output logic                  m_arvalid,
    output logic [ADDR_W-1:0]     m_araddr,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    output logic                  m_rready,
    output logic                  m_awvalid,
    output logic [ADDR_W-1:0]     m_awaddr,
    input  logic                  m_awready,
    output logic                  m_wvalid,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    input  logic [1:0]            m_bresp,
    output logic                  m_bready,
    // observability
    output logic [1:0]            grant,
    output logic                  busy
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_IR_A = 3'd1;
    localparam logic [2:0] ST_IR_D = 3'd2;
    localparam logic [2:0] ST_LR_A = 3'd3;
    localparam logic [2:0] ST_LR_D = 3'd4;
    localparam logic [2:0] ST_LW_A = 3'd5;
    localparam logic [2:0] ST_LW_B = 3'd6;

    localparam logic LSU_FIRST = (PRIO_LSU != 0) ? 1'b1 : 1'b0;

    // Grant encoding seen by observers for a given state.
    function automatic logic [1:0] grant_of(input logic [2:0] st);
        case (st)
            ST_IR_A, ST_IR_D: grant_of = 2'b01;
            ST_LR_A, ST_LR_D: grant_of = 2'b10;
            ST_LW_A, ST_LW_B: grant_of = 2'b11;
            default:          grant_of = 2'b00;
        endcase
    endfunction

    logic [2:0] state_r, state_nxt_s;
    logic       last_lsu_r, last_lsu_nxt_s;   // 1: last grant went to LSU
    logic       aw_done_r, aw_done_nxt_s;
    logic       w_done_r, w_done_nxt_s;
    logic [1:0] grant_r;
    logic       busy_r;
    logic       lsu_req_s;
    logic       lsu_win_s;
    logic       aw_fin_s;
    logic       w_fin_s;

    assign lsu_req_s = lsu_awvalid | lsu_arvalid;
    // With round-robin, the LSU only loses a conflict if it was served last.
    assign lsu_win_s = lsu_req_s & (LSU_FIRST | ~ifu_arvalid | ~last_lsu_r);
    assign aw_fin_s  = aw_done_r | m_awready;
    assign w_fin_s   = w_done_r | m_wready;

    // Next-state, last-grant and write-handshake flag computation.
    always_comb begin
        state_nxt_s    = state_r;
        last_lsu_nxt_s = last_lsu_r;
        aw_done_nxt_s  = aw_done_r;
        w_done_nxt_s   = w_done_r;
        case (state_r)
            ST_IDLE: begin
                if (lsu_win_s) begin
                    last_lsu_nxt_s = 1'b1;
                    aw_done_nxt_s  = 1'b0;
                    w_done_nxt_s   = 1'b0;
                    state_nxt_s    = lsu_awvalid ? ST_LW_A : ST_LR_A;
                end else if (ifu_arvalid) begin
                    last_lsu_nxt_s = 1'b0;
                    state_nxt_s    = ST_IR_A;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_IR_A: begin
                if (m_arready) state_nxt_s = ST_IR_D;
                else           state_nxt_s = ST_IR_A;
            end
            ST_IR_D: begin
                if (m_rvalid & ifu_rready) state_nxt_s = ST_IDLE;
                else                       state_nxt_s = ST_IR_D;
            end
            ST_LR_A: begin
                if (m_arready) state_nxt_s = ST_LR_D;
                else           state_nxt_s = ST_LR_A;
            end
            ST_LR_D: begin
                if (m_rvalid & lsu_rready) state_nxt_s = ST_IDLE;
                else                       state_nxt_s = ST_LR_D;
            end
            ST_LW_A: begin
                // AW and W complete independently; both done (possibly in the same cycle) moves on.
                if (aw_fin_s & w_fin_s) begin
                    state_nxt_s   = ST_LW_B;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                end else begin
                    aw_done_nxt_s = aw_fin_s;
                    w_done_nxt_s  = w_fin_s;
                end
            end
            ST_LW_B: begin
                if (m_bvalid & lsu_bready) state_nxt_s = ST_IDLE;
                else                       state_nxt_s = ST_LW_B;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, arbitration history and observability registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            last_lsu_r <= 1'b0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            grant_r    <= 2'b00;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            last_lsu_r <= last_lsu_nxt_s;
            aw_done_r  <= aw_done_nxt_s;
            w_done_r   <= w_done_nxt_s;
            grant_r    <= grant_of(state_nxt_s);
            busy_r     <= (state_nxt_s != ST_IDLE);
        end
    end

    assign grant = grant_r;
    assign busy  = busy_r;

    // Channel steering: only the granted master sees the slave's handshakes.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = {DATA_W{1'b0}};
        ifu_rresp   = 2'b00;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = {DATA_W{1'b0}};
        lsu_rresp   = 2'b00;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = 2'b00;
        m_arvalid   = 1'b0;
        m_araddr    = {ADDR_W{1'b0}};
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_awaddr    = {ADDR_W{1'b0}};
        m_wvalid    = 1'b0;
        m_wdata     = {DATA_W{1'b0}};
        m_wstrb     = {(DATA_W/8){1'b0}};
        m_bready    = 1'b0;
        case (state_r)
            ST_IR_A: begin
                m_arvalid   = 1'b1;
                m_araddr    = ifu_araddr;
                ifu_arready = m_arready;
            end
            ST_IR_D: begin
                ifu_rvalid = m_rvalid;
                ifu_rdata  = m_rdata;
                ifu_rresp  = m_rresp;
                m_rready   = ifu_rready;
            end
            ST_LR_A: begin
                m_arvalid   = 1'b1;
                m_araddr    = lsu_araddr;
                lsu_arready = m_arready;
            end
            ST_LR_D: begin
                lsu_rvalid = m_rvalid;
                lsu_rdata  = m_rdata;
                lsu_rresp  = m_rresp;
                m_rready   = lsu_rready;
            end
            ST_LW_A: begin
                m_awvalid   = ~aw_done_r;
                m_awaddr    = lsu_awaddr;
                lsu_awready = ~aw_done_r & m_awready;
                m_wvalid    = ~w_done_r;
                m_wdata     = lsu_wdata;
                m_wstrb     = lsu_wstrb;
                lsu_wready  = ~w_done_r & m_wready;
            end
            ST_LW_B: begin
                lsu_bvalid = m_bvalid;
                lsu_bresp  = m_bresp;
                m_bready   = lsu_bready;
            end
            default: begin
                m_arvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed testbench for axi_lite_mem_arbiter: a fixed-priority instance
// with a small registered RAM responder, plus a round-robin instance with an
// always-ready responder for the alternation check.
module tb_axi_lite_mem_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // main instance (PRIO_LSU=1)
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr;
    logic [63:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_awaddr;
    logic [63:0] lsu_rdata, lsu_wdata;
    logic [1:0]  lsu_rresp, lsu_bresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [7:0]  lsu_wstrb;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_araddr, m_awaddr;
    logic [63:0] m_rdata, m_wdata;
    logic [1:0]  m_rresp, m_bresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [7:0]  m_wstrb;
    logic [1:0]  grant;
    logic        busy;

    axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .PRIO_LSU(1)) dut (
        .clk(clk), .resetn(resetn),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
        .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .grant(grant), .busy(busy)
    );

    // RAM responder: zero-wait AR, read data one cycle later as {addr, ~addr},
    // W accepted two cycles after AW, SLVERR for addresses 0xFxxxxxxx.
    logic        s_rvalid, s_aw_seen, s_bvalid;
    logic [63:0] s_rdata, s_wdata;
    logic [1:0]  s_rresp, s_bresp;
    logic [1:0]  s_wcnt;
    logic [31:0] s_awaddr;
    logic [7:0]  s_wstrb;

    assign m_arready = 1'b1;
    assign m_rvalid  = s_rvalid;
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_awready = ~s_aw_seen & ~s_bvalid;
    assign m_wready  = s_aw_seen & (s_wcnt == 2'd0);
    assign m_bvalid  = s_bvalid;
    assign m_bresp   = s_bresp;

    // responder state
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_rvalid <= 1'b0; s_rdata <= 64'd0; s_rresp <= 2'b00;
            s_aw_seen <= 1'b0; s_wcnt <= 2'd0; s_awaddr <= 32'd0;
            s_bvalid <= 1'b0; s_bresp <= 2'b00; s_wdata <= 64'd0; s_wstrb <= 8'd0;
        end else begin
            if (m_arvalid && m_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= {m_araddr, ~m_araddr};
                s_rresp  <= (m_araddr[31:28] == 4'hF) ? 2'b10 : 2'b00;
            end else if (s_rvalid && m_rready) begin
                s_rvalid <= 1'b0;
            end
            if (m_awvalid && m_awready) begin
                s_aw_seen <= 1'b1; s_wcnt <= 2'd1; s_awaddr <= m_awaddr;
            end else if (s_wcnt != 2'd0) begin
                s_wcnt <= s_wcnt - 2'd1;
            end
            if (m_wvalid && m_wready) begin
                s_aw_seen <= 1'b0; s_bvalid <= 1'b1;
                s_wdata <= m_wdata; s_wstrb <= m_wstrb;
                s_bresp <= (s_awaddr[31:28] == 4'hF) ? 2'b10 : 2'b00;
            end else if (s_bvalid && m_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    // round-robin instance (PRIO_LSU=0) with an always-ready responder
    logic        rr_ifu_arvalid, rr_lsu_arvalid;
    logic        rr_ifu_arready, rr_ifu_rvalid, rr_lsu_arready, rr_lsu_rvalid;
    logic [63:0] rr_ifu_rdata, rr_lsu_rdata, rr_m_wdata;
    logic [1:0]  rr_ifu_rresp, rr_lsu_rresp, rr_lsu_bresp, rr_grant;
    logic        rr_lsu_awready, rr_lsu_wready, rr_lsu_bvalid;
    logic        rr_m_arvalid, rr_m_rready, rr_m_awvalid, rr_m_wvalid, rr_m_bready, rr_busy;
    logic [31:0] rr_m_araddr, rr_m_awaddr;
    logic [7:0]  rr_m_wstrb;

    axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .PRIO_LSU(0)) dut_rr (
        .clk(clk), .resetn(resetn),
        .ifu_arvalid(rr_ifu_arvalid), .ifu_araddr(32'h8000_0000), .ifu_arready(rr_ifu_arready),
        .ifu_rvalid(rr_ifu_rvalid), .ifu_rdata(rr_ifu_rdata), .ifu_rresp(rr_ifu_rresp), .ifu_rready(1'b1),
        .lsu_arvalid(rr_lsu_arvalid), .lsu_araddr(32'h8000_0040), .lsu_arready(rr_lsu_arready),
        .lsu_rvalid(rr_lsu_rvalid), .lsu_rdata(rr_lsu_rdata), .lsu_rresp(rr_lsu_rresp), .lsu_rready(1'b1),
        .lsu_awvalid(1'b0), .lsu_awaddr(32'd0), .lsu_awready(rr_lsu_awready),
        .lsu_wvalid(1'b0), .lsu_wdata(64'd0), .lsu_wstrb(8'd0), .lsu_wready(rr_lsu_wready),
        .lsu_bvalid(rr_lsu_bvalid), .lsu_bresp(rr_lsu_bresp), .lsu_bready(1'b1),
        .m_arvalid(rr_m_arvalid), .m_araddr(rr_m_araddr), .m_arready(1'b1),
        .m_rvalid(1'b1), .m_rdata(64'h0123_4567_89AB_CDEF), .m_rresp(2'b00), .m_rready(rr_m_rready),
        .m_awvalid(rr_m_awvalid), .m_awaddr(rr_m_awaddr), .m_awready(1'b1),
        .m_wvalid(rr_m_wvalid), .m_wdata(rr_m_wdata), .m_wstrb(rr_m_wstrb), .m_wready(1'b1),
        .m_bvalid(1'b1), .m_bresp(2'b00), .m_bready(rr_m_bready),
        .grant(rr_grant), .busy(rr_busy)
    );

    // monitors: grant sequence, cross-master ready leakage, handshake counts
    logic [1:0] glog[$];
    logic [1:0] rrlog[$];
    logic [1:0] prev_grant = 2'b00;
    logic [1:0] rr_prev_grant = 2'b00;
    int xviol = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt = 0;

    // record grant entries and protocol observations once per cycle
    always @(negedge clk) begin
        if (grant != prev_grant && grant != 2'b00) glog.push_back(grant);
        prev_grant <= grant;
        if (rr_grant != rr_prev_grant && rr_grant != 2'b00) rrlog.push_back(rr_grant);
        rr_prev_grant <= rr_grant;
        if ((grant == 2'b10 || grant == 2'b11) && ifu_arready) xviol <= xviol + 1;
        if (grant == 2'b01 && (lsu_arready || lsu_awready || lsu_wready)) xviol <= xviol + 1;
        if (m_awvalid && m_awready) aw_hs_cnt <= aw_hs_cnt + 1;
        if (m_wvalid && m_wready) w_hs_cnt <= w_hs_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic ifu_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] r);
        int n;
        ifu_arvalid = 1'b1; ifu_araddr = a; ifu_rready = 1'b1; n = 0;
        #1;
        while (!ifu_arready && n < 50) begin @(negedge clk); #1; n++; end
        check_eq("ifu_ar_wait", 64'(n < 50), 64'd1);
        @(negedge clk);
        ifu_arvalid = 1'b0; n = 0;
        #1;
        while (!ifu_rvalid && n < 50) begin @(negedge clk); #1; n++; end
        check_eq("ifu_r_wait", 64'(n < 50), 64'd1);
        d = ifu_rdata; r = ifu_rresp;
        @(negedge clk);
    endtask

    task automatic lsu_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] r);
        int n;
        lsu_arvalid = 1'b1; lsu_araddr = a; lsu_rready = 1'b1; n = 0;
        #1;
        while (!lsu_arready && n < 50) begin @(negedge clk); #1; n++; end
        check_eq("lsu_ar_wait", 64'(n < 50), 64'd1);
        @(negedge clk);
        lsu_arvalid = 1'b0; n = 0;
        #1;
        while (!lsu_rvalid && n < 50) begin @(negedge clk); #1; n++; end
        check_eq("lsu_r_wait", 64'(n < 50), 64'd1);
        d = lsu_rdata; r = lsu_rresp;
        @(negedge clk);
    endtask

    task automatic lsu_write(input logic [31:0] a, input logic [63:0] dat, input logic [7:0] strb,
                             output logic [1:0] br, output int redrive);
        int n;
        logic awd, wd, ah, wh;
        lsu_awvalid = 1'b1; lsu_awaddr = a; lsu_wvalid = 1'b1; lsu_wdata = dat; lsu_wstrb = strb;
        lsu_bready = 1'b1; awd = 1'b0; wd = 1'b0; n = 0; redrive = 0;
        #1;
        while (!(awd && wd) && n < 50) begin
            ah = lsu_awvalid && lsu_awready;
            wh = lsu_wvalid && lsu_wready;
            if (awd && m_awvalid) redrive++;
            @(negedge clk);
            if (ah) begin lsu_awvalid = 1'b0; awd = 1'b1; end
            if (wh) begin lsu_wvalid = 1'b0; wd = 1'b1; end
            #1; n++;
        end
        check_eq("lsu_aw_w_wait", 64'(n < 50), 64'd1);
        n = 0;
        while (!lsu_bvalid && n < 50) begin @(negedge clk); #1; n++; end
        check_eq("lsu_b_wait", 64'(n < 50), 64'd1);
        br = lsu_bresp;
        @(negedge clk);
    endtask

    logic [63:0] d1, d2;
    logic [1:0]  r1, r2, br;
    int rd, v0, awc0, wc0;

    initial begin
        ifu_arvalid = 1'b0; ifu_araddr = 32'd0; ifu_rready = 1'b0;
        lsu_arvalid = 1'b0; lsu_araddr = 32'd0; lsu_rready = 1'b0;
        lsu_awvalid = 1'b0; lsu_awaddr = 32'd0; lsu_wvalid = 1'b0;
        lsu_wdata = 64'd0; lsu_wstrb = 8'd0; lsu_bready = 1'b0;
        rr_ifu_arvalid = 1'b0; rr_lsu_arvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        // reset state
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 64'd0);
        check_eq("rst_readies", 64'({ifu_arready, lsu_arready, lsu_awready, lsu_wready}), 64'd0);
        check_eq("rst_araddr", 64'(m_araddr), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // 1: IFU-only read, cycle accurate
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_rready = 1'b1;
        #1;
        check_eq("t1_c0_arvalid", 64'(m_arvalid), 64'd0);
        @(negedge clk); #1;
        check_eq("t1_c1_arvalid", 64'(m_arvalid), 64'd1);
        check_eq("t1_c1_araddr", 64'(m_araddr), 64'h8000_0000);
        check_eq("t1_c1_grant", 64'(grant), 64'd1);
        check_eq("t1_c1_arready", 64'(ifu_arready), 64'd1);
        @(negedge clk);
        ifu_arvalid = 1'b0;
        #1;
        check_eq("t1_c2_rvalid", 64'(ifu_rvalid), 64'd1);
        check_eq("t1_c2_rdata", ifu_rdata, 64'h8000_0000_7FFF_FFFF);
        check_eq("t1_c2_rresp", 64'(ifu_rresp), 64'd0);
        @(negedge clk); #1;
        check_eq("t1_c3_grant", 64'(grant), 64'd0);
        check_eq("t1_c3_busy", 64'(busy), 64'd0);
        @(negedge clk);

        // 3: round-robin instance, both masters requesting for 4 transactions
        rr_ifu_arvalid = 1'b1; rr_lsu_arvalid = 1'b1;
        repeat (12) @(negedge clk);
        rr_ifu_arvalid = 1'b0; rr_lsu_arvalid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t3_count", 64'(rrlog.size()), 64'd4);
        check_eq("t3_g0", 64'(rrlog[0]), 64'd2);
        check_eq("t3_g1", 64'(rrlog[1]), 64'd1);
        check_eq("t3_g2", 64'(rrlog[2]), 64'd2);
        check_eq("t3_g3", 64'(rrlog[3]), 64'd1);

        // 2: simultaneous IFU and LSU reads, LSU first
        glog.delete(); v0 = xviol;
        fork
            ifu_read(32'h8000_0008, d1, r1);
            lsu_read(32'h8000_0010, d2, r2);
        join
        check_eq("t2_count", 64'(glog.size()), 64'd2);
        check_eq("t2_first", 64'(glog[0]), 64'd2);
        check_eq("t2_second", 64'(glog[1]), 64'd1);
        check_eq("t2_no_leak", 64'(xviol - v0), 64'd0);
        check_eq("t2_ifu_data", d1, 64'h8000_0008_7FFF_FFF7);
        check_eq("t2_lsu_data", d2, 64'h8000_0010_7FFF_FFEF);

        // error response passes through unchanged
        lsu_read(32'hF000_0000, d2, r2);
        check_eq("err_rresp", 64'(r2), 64'd2);
        check_eq("err_rdata", d2, 64'hF000_0000_0FFF_FFFF);

        // 4: LSU write with W accepted two cycles after AW
        glog.delete(); awc0 = aw_hs_cnt; wc0 = w_hs_cnt;
        lsu_write(32'h8000_1000, 64'h1122_3344_5566_7788, 8'h0F, br, rd);
        check_eq("t4_grant", 64'(glog[0]), 64'd3);
        check_eq("t4_aw_hs", 64'(aw_hs_cnt - awc0), 64'd1);
        check_eq("t4_w_hs", 64'(w_hs_cnt - wc0), 64'd1);
        check_eq("t4_aw_redrive", 64'(rd), 64'd0);
        check_eq("t4_awaddr", 64'(s_awaddr), 64'h8000_1000);
        check_eq("t4_wdata", s_wdata, 64'h1122_3344_5566_7788);
        check_eq("t4_wstrb", 64'(s_wstrb), 64'h0F);
        check_eq("t4_bresp", 64'(br), 64'd0);
        check_eq("t4_idle", 64'({busy, grant}), 64'd0);

        // 5: LSU write and read together, write first
        glog.delete();
        fork
            lsu_write(32'h8000_2000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, br, rd);
            lsu_read(32'h8000_2000, d2, r2);
        join
        check_eq("t5_count", 64'(glog.size()), 64'd2);
        check_eq("t5_first", 64'(glog[0]), 64'd3);
        check_eq("t5_second", 64'(glog[1]), 64'd2);
        check_eq("t5_rdata", d2, 64'h8000_2000_7FFF_DFFF);
        check_eq("t5_wdata", s_wdata, 64'hDEAD_BEEF_CAFE_F00D);

        lsu_write(32'hF000_0040, 64'h55, 8'h01, br, rd);
        check_eq("err_bresp", 64'(br), 64'd2);

        // 6: reset while a read response is pending
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0100; ifu_rready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ifu_arvalid = 1'b0;
        #1;
        check_eq("t6_pending", 64'({grant, ifu_rvalid}), 64'h3);
        resetn = 1'b0;
        #1;
        check_eq("t6_rst_grant", 64'({busy, grant}), 64'd0);
        check_eq("t6_rst_valids", 64'({m_arvalid, m_rready, ifu_rvalid, ifu_arready, lsu_rvalid, lsu_bvalid}), 64'd0);
        @(negedge clk); #1;
        check_eq("t6_rst_hold", 64'({busy, grant}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        ifu_read(32'h8000_0100, d1, r1);
        check_eq("t6_after_data", d1, 64'h8000_0100_7FFF_FEFF);
        check_eq("t6_after_resp", 64'(r1), 64'd0);
        check_eq("leak_total", 64'(xviol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
